// File: rtl/bcd_chain_counter.sv
// Cascaded BCD/modulo digit counter with synchronous ripple carry, clear and parallel load.
// Define BCD_CHAIN_COUNTER_DOWN_EN to add the dir input (1 = count down, 0 = count up).
module bcd_chain_counter #(
  parameter int          NDIG    = 4,
  parameter logic [31:0] MOD_VEC = 32'h00006A6A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cin,
  input  logic              clr,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
`ifdef BCD_CHAIN_COUNTER_DOWN_EN
  input  logic              dir,
`endif
  output logic [4*NDIG-1:0] cnt,
  output logic              cout,
  output logic              tc
);

  logic              down;
  logic [NDIG-1:0]   at_max;
  logic [NDIG-1:0]   at_zero;
  logic [NDIG-1:0]   lim;
  logic [NDIG:0]     en;
  logic [4*NDIG-1:0] cnt_step;
  logic [4*NDIG-1:0] cnt_load;

`ifdef BCD_CHAIN_COUNTER_DOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  // en[i] is the step enable for digit i; en[NDIG] means the whole chain wraps this edge.
  assign en[0] = cin;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam logic [3:0] MAXV = MOD_VEC[4*i +: 4] - 4'd1;

    logic [3:0] dig;
    logic [3:0] ld;
    logic [3:0] dig_up;
    logic [3:0] dig_dn;

    assign dig        = cnt[4*i +: 4];
    assign ld         = load_val[4*i +: 4];
    assign at_max[i]  = (dig == MAXV);
    assign at_zero[i] = (dig == 4'd0);
    assign lim[i]     = down ? at_zero[i] : at_max[i];
    assign en[i+1]    = en[i] & lim[i];

    assign dig_up = at_max[i]  ? 4'd0 : dig + 4'd1;
    assign dig_dn = at_zero[i] ? MAXV : dig - 4'd1;

    assign cnt_step[4*i +: 4] = !en[i] ? dig : (down ? dig_dn : dig_up);
    // Out-of-range load digits collapse to 0 so every digit stays inside its modulo.
    assign cnt_load[4*i +: 4] = (ld <= MAXV) ? ld : 4'd0;
  end

  assign tc = &lim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      cout <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      cout <= 1'b0;
    end else if (load) begin
      cnt  <= cnt_load;
      cout <= 1'b0;
    end else if (cin) begin
      cnt  <= cnt_step;
      cout <= en[NDIG];
    end else begin
      cout <= 1'b0;
    end
  end

endmodule
